// File: rtl/answer_arbiter.sv
// Front-end arbiter for the answering machine: per-channel synchroniser and debounce,
// first-press lock, countdown handshake. Define FALSE_START_EN to enable false-start fouls.
module answer_arbiter #(
    parameter int N          = 8,
    parameter int DEB_CYCLES = 20,
    parameter int DEB_W      = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn,
    input  logic         host_start,
    input  logic         host_clear,
    input  logic         time_up,
    output logic         run_pause,
    output logic         winner_valid,
    output logic [3:0]   winner_id,
    output logic [N-1:0] lock_led,
    output logic         timeout,
    output logic [N-1:0] foul
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;
    localparam logic [1:0] S_TIMEOUT = 2'd3;

    logic [N-1:0]     sync1_q, sync2_q, filt_q, filt_prev_q;
    logic [DEB_W-1:0] cnt_q [N];
    logic [N-1:0]     press, elig;

    // NOTE: every register here, including the per-channel counters, is a small flop
    // bank rather than a memory, so all of it is reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep sync1 -> sync2 a true two-stage pipeline.
            sync1_q     <= btn;
            sync2_q     <= sync1_q;
            filt_prev_q <= filt_q;
            for (int i = 0; i < N; i++) begin
                if (sync2_q[i] != filt_q[i]) begin
                    if (cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
                        filt_q[i] <= ~filt_q[i];
                        cnt_q[i]  <= '0;
                    end else begin
                        cnt_q[i]  <= cnt_q[i] + DEB_W'(1);
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign press = filt_q & ~filt_prev_q;

    logic [3:0]   pick_id;
    logic [N-1:0] pick_led;

    // Scanning downward lets the lowest eligible index overwrite higher ones.
    always_comb begin
        pick_id  = '0;
        pick_led = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i]) begin
                pick_id     = 4'(i + 1);
                pick_led    = '0;
                pick_led[i] = 1'b1;
            end
        end
    end

    logic [1:0]   state_q, state_d;
    logic         run_q, run_d;
    logic         valid_q, valid_d;
    logic [3:0]   id_q, id_d;
    logic [N-1:0] led_q, led_d;
    logic         timeout_q, timeout_d;

    // NOTE: each output of this block is given its hold value first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        valid_d   = valid_q;
        id_d      = id_q;
        led_d     = led_q;
        timeout_d = timeout_q;
        if (host_clear) begin
            state_d   = S_IDLE;
            run_d     = 1'b0;
            valid_d   = 1'b0;
            id_d      = '0;
            led_d     = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (host_start) begin
                        state_d = S_ARMED;
                        run_d   = 1'b1;
                    end
                end
                S_ARMED: begin
                    // A press beats a simultaneous time_up.
                    if (|elig) begin
                        state_d = S_LOCKED;
                        run_d   = 1'b0;
                        valid_d = 1'b1;
                        id_d    = pick_id;
                        led_d   = pick_led;
                    end else if (time_up) begin
                        state_d   = S_TIMEOUT;
                        run_d     = 1'b0;
                        timeout_d = 1'b1;
                    end
                end
                S_LOCKED:  ;
                S_TIMEOUT: ;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            run_q     <= 1'b0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            led_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            led_q     <= led_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef FALSE_START_EN
    logic [N-1:0] foul_q, foul_d;

    // Fouls survive a clear from IDLE/ARMED so a false starter stays barred for the round.
    always_comb begin
        foul_d = foul_q;
        if (state_q == S_IDLE) foul_d = foul_q | press;
        if (host_clear && (state_q == S_LOCKED || state_q == S_TIMEOUT)) foul_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) foul_q <= '0;
        else     foul_q <= foul_d;
    end

    assign elig = press & ~foul_q;
    assign foul = foul_q;
`else
    assign elig = press;
    assign foul = '0;
`endif

    assign run_pause    = run_q;
    assign winner_valid = valid_q;
    assign winner_id    = id_q;
    assign lock_led     = led_q;
    assign timeout      = timeout_q;

endmodule

// File: doc/answer_arbiter.md
Name: answer_arbiter

Overview:
- Front-end arbiter for the multichannel answering machine; sits directly upstream of the countdown display stage.
- Synchronises and debounces N contestant buttons and latches the first valid press once the host arms a round.
- Drives the countdown stage's run_pause level and consumes its time-up indication.
- Reports the winning channel for display and lock LEDs.

Parameters:
- N, 8, number of contestant channels (1..15).
- DEB_CYCLES, 20, consecutive stable clk cycles required to accept a button level change (>=1).
- DEB_W, 8, width of each per-channel debounce counter; must hold DEB_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- btn  input  N  raw contestant buttons, active-high, asynchronous to clk
- host_start  input  1  synchronous single-cycle pulse: arm a round
- host_clear  input  1  synchronous single-cycle pulse: end round, return to idle
- time_up  input  1  level from countdown stage, high when countdown finished
- run_pause  output  1  to countdown stage; 1 = count, 0 = hold
- winner_valid  output  1  high while a winner is latched
- winner_id  output  4  1-based winning channel index; 0 = none
- lock_led  output  N  one-hot winner indicator
- timeout  output  1  high when round ended with no press
- foul  output  N  sticky false-start flags (see Optional Feature)

Behaviour:
- Reset: async on rst high. All outputs 0, FSM to IDLE, sync flops 0, filtered levels 0, debounce counters 0, foul 0.
- Per channel: 2-flop synchroniser, then debounce filter.
  - Counter increments while the synced value differs from the filtered level; cleared when they match.
  - When the count reaches DEB_CYCLES, the filtered level toggles and the counter clears.
- press[i]: single-cycle pulse on the rising edge of filtered[i]. Falling edges generate nothing.
- FSM states: IDLE, ARMED, LOCKED, TIMEOUT.
- IDLE:
  - All status outputs 0.
  - host_start -> ARMED.
  - Presses are ignored (or fouled, see Optional Feature).
- ARMED:
  - run_pause=1.
  - Any press[i] of an eligible channel -> LOCKED.
  - Simultaneous presses: lowest index wins.
  - winner_id=i+1, lock_led[i]=1 and winner_valid=1 are all registered on the transition edge.
  - run_pause=0 from the same edge.
  - time_up high with no eligible press in that cycle -> TIMEOUT, timeout=1, run_pause=0.
  - Press and time_up in the same cycle: the press wins (LOCKED).
- LOCKED: outputs held. Further presses and time_up are ignored. host_clear -> IDLE.
- TIMEOUT: outputs held. Presses are ignored. host_clear -> IDLE.
- host_clear in any state:
  - Next state IDLE.
  - winner_valid, winner_id, lock_led, timeout and run_pause cleared on the same edge.
- host_start outside IDLE: ignored.
- host_start and host_clear in the same cycle: clear wins, state becomes IDLE.
- Latency: btn rising and held stable -> winner_valid high exactly DEB_CYCLES+3 clk edges after the first edge that samples btn high (ARMED throughout).
- Glitches shorter than DEB_CYCLES cycles never produce press.
- rst mid-round: immediate return to the reset state. A button still held after reset release debounces to filtered=1, and its rising edge produces a press only in IDLE, never a win.

Optional Feature:
- Macro FALSE_START_EN.
- Defined:
  - press[i] in IDLE sets foul[i] (sticky).
  - A fouled channel is ineligible in ARMED. Its presses are ignored and it cannot be chosen even if it has the lowest index.
  - foul clears only on rst or on host_clear while in LOCKED/TIMEOUT.
  - If all channels are fouled, the round runs until time_up and then goes to TIMEOUT.
- Undefined: foul tied to 0; all channels always eligible; IDLE presses discarded.

Test Plan:
- rst pulse, then host_start, hold btn[3]=1 -> run_pause=1 from the cycle after host_start; after DEB_CYCLES+3 edges winner_valid=1, winner_id=4, lock_led=8'h08, run_pause=0.
- ARMED, btn[5] and btn[2] rise on the same edge -> winner_id=3, lock_led=8'h04; a later btn[0] press leaves the outputs unchanged; host_clear -> all 0, IDLE.
- ARMED, btn[1] pulses high for DEB_CYCLES-1 cycles only -> no win. Then assert time_up -> timeout=1, run_pause=0, winner_id=0.
- ARMED, press pulse coincides with the first time_up cycle on btn[6] -> LOCKED, winner_id=7, timeout=0.
- Assert rst while LOCKED -> all outputs 0 asynchronously; host_start and host_clear in the same cycle afterwards -> remains IDLE.
- FALSE_START_EN: press btn[0] in IDLE -> foul=8'h01. host_start, then btn[0] and btn[4] pressed together -> winner_id=5. host_clear -> foul=0.
